// File: rtl/video_stream_gen.sv
// Synthetic RGB test-pattern source: 2-clock pixel slots, programmable geometry,
// per-frame pattern latch and a wrapping frame counter.
module video_stream_gen #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_BLANK    = 160,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_BLANK    = 45
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            pattern,
  output logic                  rgb_valid,
  output logic                  rgb_hsync,
  output logic                  rgb_vsync,
  output logic [DATA_WIDTH-1:0] r,
  output logic [DATA_WIDTH-1:0] g,
  output logic [DATA_WIDTH-1:0] b,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
  // Counters keep at least 4 bits so the checkerboard can always read bit 3.
  localparam int unsigned HW    = ($clog2(H_TOTAL) > 4) ? $clog2(H_TOTAL) : 4;
  localparam int unsigned VW    = ($clog2(V_TOTAL) > 4) ? $clog2(V_TOTAL) : 4;
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned FCW   = 16;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_VBLANK} state_e;

  state_e                state_q, state_d;
  logic                  phase_q, phase_d;
  logic [HW-1:0]         h_cnt_q, h_cnt_d;
  logic [VW-1:0]         v_cnt_q, v_cnt_d;
  logic [1:0]            pat_q, pat_d;
  logic [DATA_WIDTH-1:0] solid_q, solid_d;

  logic                  valid_q, valid_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic [DATA_WIDTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                  fdone_q, fdone_d;
  logic [FCW-1:0]        fcnt_q, fcnt_d;

  logic line_end_c, last_act_line_c, last_line_c, frame_end_c, frame_start_c;

  assign line_end_c      = phase_q && (h_cnt_q == HW'(H_TOTAL - 1));
  assign last_act_line_c = (v_cnt_q == VW'(V_ACTIVE - 1));
  assign last_line_c     = (v_cnt_q == VW'(V_TOTAL - 1));
  assign frame_end_c     = (state_q == S_VBLANK) && line_end_c && last_line_c;
  assign frame_start_c   = enable && ((state_q == S_IDLE) || frame_end_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (enable) state_d = S_ACTIVE;
      S_ACTIVE: if (line_end_c && last_act_line_c) state_d = S_VBLANK;
      S_VBLANK: if (frame_end_c) state_d = enable ? S_ACTIVE : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Slot/line counters plus per-frame latches of pattern and solid level.
  always_comb begin
    phase_d = phase_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    pat_d   = pat_q;
    solid_d = solid_q;
    if (state_q == S_IDLE) begin
      phase_d = 1'b0;
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else begin
      phase_d = ~phase_q;
      if (phase_q) begin
        if (h_cnt_q == HW'(H_TOTAL - 1)) begin
          h_cnt_d = '0;
          v_cnt_d = last_line_c ? '0 : v_cnt_q + VW'(1);
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
      end
    end
    if (frame_start_c) begin
      pat_d   = pattern;
      solid_d = DATA_WIDTH'(fcnt_d);
    end
  end

  // Output next-values: computed from the current slot, presented one clock later.
  always_comb begin
    logic                  act_slot;
    logic [2:0]            bar;
    logic [DATA_WIDTH-1:0] pr, pg, pb;
    act_slot = (state_q == S_ACTIVE) && (h_cnt_q < HW'(H_ACTIVE));
    bar      = 3'(h_cnt_q / HW'(BAR_W));
    pr       = '0;
    pg       = '0;
    pb       = '0;
    unique case (pat_q)
      2'd0: begin
        pr = {DATA_WIDTH{~bar[1]}};
        pg = {DATA_WIDTH{~bar[2]}};
        pb = {DATA_WIDTH{~bar[0]}};
      end
      2'd1: begin
        pr = DATA_WIDTH'(h_cnt_q);
        pg = DATA_WIDTH'(h_cnt_q);
        pb = DATA_WIDTH'(h_cnt_q);
      end
      2'd2: begin
        pr = {DATA_WIDTH{h_cnt_q[3] ^ v_cnt_q[3]}};
        pg = pr;
        pb = pr;
      end
      default: begin
        pr = solid_q;
        pg = solid_q;
        pb = solid_q;
      end
    endcase
    valid_d = act_slot && !phase_q;
    hsync_d = act_slot;
    vsync_d = (state_q == S_ACTIVE);
    r_d     = act_slot ? pr : '0;
    g_d     = act_slot ? pg : '0;
    b_d     = act_slot ? pb : '0;
    fdone_d = frame_end_c;
    fcnt_d  = fcnt_q + FCW'(frame_end_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      pat_q   <= '0;
      solid_q <= '0;
      valid_q <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      fdone_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      phase_q <= phase_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      pat_q   <= pat_d;
      solid_q <= solid_d;
      valid_q <= valid_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      fdone_q <= fdone_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign rgb_valid  = valid_q;
  assign rgb_hsync  = hsync_q;
  assign rgb_vsync  = vsync_q;
  assign r          = r_q;
  assign g          = g_q;
  assign b          = b_q;
  assign frame_done = fdone_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_video_stream_gen.sv
// Bench for video_stream_gen on a tiny 8+4 x 4+2 raster: frame-time reference
// model compared every clock, plus table and hand-written corner sequences.
module tb_video_stream_gen;

  localparam int HA = 8, HB = 4, VA = 4, VB = 2;
  localparam int HT = HA + HB, VT = VA + VB;
  localparam int FRAME = 2 * HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern = 2'd1;
  logic        rgb_valid, rgb_hsync, rgb_vsync, frame_done;
  logic [7:0]  r, g, b;
  logic [15:0] frame_cnt;

  video_stream_gen #(
    .DATA_WIDTH(8), .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern(pattern),
    .rgb_valid(rgb_valid), .rgb_hsync(rgb_hsync), .rgb_vsync(rgb_vsync),
    .r(r), .g(g), .b(b), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  logic [23:0] bars [8];
  initial bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                   24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [23:0] pixel(input logic [1:0] p, input int h, input int line,
                                        input logic [7:0] s);
    case (p)
      2'd0:    return bars[h / (HA / 8)];
      2'd1:    return {3{8'(h)}};
      2'd2:    return (((h / 8) % 2) != ((line / 8) % 2)) ? 24'hFFFFFF : 24'h0;
      default: return {3{s}};
    endcase
  endfunction

  // Reference: m_c is the clock index within the frame being generated (-1 = idle).
  logic [43:0] exp_o = '0;
  int          m_c = -1;
  logic [15:0] m_fc = '0;
  logic [1:0]  m_pat = '0;
  logic [7:0]  m_sol = '0;
  logic        preset_req = 1'b0;
  logic        chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int slot, line, h;
    logic [15:0] fc;
    logic ev, ehs, evs, efd;
    logic [23:0] px;
    if (!rst_n) begin
      exp_o <= '0;
      m_c   <= -1;
      m_fc  <= '0;
      m_pat <= '0;
      m_sol <= '0;
    end else begin
      fc = preset_req ? 16'hFFFF : m_fc;
      ev = 1'b0; ehs = 1'b0; evs = 1'b0; efd = 1'b0; px = '0;
      if (m_c >= 0) begin
        slot = m_c / 2;
        line = slot / HT;
        h    = slot % HT;
        efd  = (m_c == FRAME - 1);
        if (line < VA) begin
          evs = 1'b1;
          if (h < HA) begin
            ehs = 1'b1;
            ev  = ((m_c % 2) == 0);
            px  = pixel(m_pat, h, line, m_sol);
          end
        end
      end
      if (efd) fc = fc + 16'd1;
      exp_o <= {ev, ehs, evs, px, efd, fc};
      m_fc  <= fc;
      if (m_c < 0 || efd) begin
        if (enable) begin
          m_c   <= 0;
          m_pat <= pattern;
          m_sol <= fc[7:0];
        end else begin
          m_c <= -1;
        end
      end else begin
        m_c <= m_c + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("model", 64'({rgb_valid, rgb_hsync, rgb_vsync, r, g, b, frame_done, frame_cnt}),
            64'(exp_o));
  end

  // which: 0 = vsync, 1 = frame_done; n = negedges waited minus one, -1 on timeout.
  task automatic wait_sig(input int which, input int limit, output int n);
    n = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((which == 0 && rgb_vsync) || (which == 1 && frame_done)) begin
        n = i;
        return;
      end
    end
  endtask

  int vs_n, val_n, hs0_n, fd_at;
  logic [23:0] cap [4][8];

  // Called on the negedge showing clock 0 of a frame; consumes the whole frame.
  task automatic measure_frame(input int pidx);
    int pc;
    vs_n = 0; val_n = 0; hs0_n = 0; fd_at = -1; pc = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      if (rgb_vsync) vs_n++;
      if (rgb_valid) val_n++;
      if (i < 2 * HT && rgb_hsync) hs0_n++;
      if (i < 2 * HT && rgb_valid && pc < 8) begin
        cap[pidx][pc] = {r, g, b};
        pc++;
      end
      if (frame_done && fd_at < 0) fd_at = i;
    end
  endtask

  typedef struct {
    logic [1:0]  pat;
    int          idx;
    logic [23:0] rgb;
  } vec_t;
  vec_t tbl [16];

  initial begin
    int n;
    int vs_seen;
    for (int i = 0; i < 8; i++) begin
      tbl[i]     = '{2'd0, i, bars[i]};
      tbl[8 + i] = '{2'd1, i, {3{8'(i)}}};
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("reset outputs", 64'({rgb_valid, rgb_hsync, rgb_vsync, r, g, b, frame_done, frame_cnt}), 64'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    enable = 1'b1;
    pattern = 2'd1;

    // Ramp frames: start latency, line/frame shape, frame period
    wait_sig(0, 20, n);
    check("start latency", 64'(n), 64'd1);
    measure_frame(1);
    check("vsync clocks", 64'(vs_n), 64'd96);
    check("valid pulses", 64'(val_n), 64'd32);
    check("hsync line0", 64'(hs0_n), 64'd16);
    check("frame_done pos", 64'(fd_at), 64'(FRAME - 1));
    @(negedge clk);
    check("no gap vsync", 64'(rgb_vsync), 64'd1);
    pattern = 2'd0;
    measure_frame(1);
    check("frame_done pos 2", 64'(fd_at), 64'(FRAME - 1));
    @(negedge clk);
    measure_frame(0);
    for (int i = 0; i < 16; i++)
      check($sformatf("pix p%0d x%0d", tbl[i].pat, tbl[i].idx),
            64'(cap[tbl[i].pat][tbl[i].idx]), 64'(tbl[i].rgb));

    // Asynchronous reset at clock 50 of a frame
    @(negedge clk);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("async reset", 64'({rgb_valid, rgb_hsync, rgb_vsync, r, g, b, frame_done, frame_cnt}), 64'd0);
    repeat (3) @(negedge clk);
    pattern = 2'd2;
    rst_n = 1'b1;
    wait_sig(0, 20, n);
    check("restart latency", 64'(n), 64'd1);
    check("restart slot0", 64'({rgb_valid, rgb_hsync, r, frame_cnt}), 64'({1'b1, 1'b1, 8'd0, 16'd0}));

    // Pattern 2 -> 3 mid-frame: next frame is solid at the new frame count
    repeat (30) @(negedge clk);
    pattern = 2'd3;
    wait_sig(1, 300, n);
    check("fc after frame0", 64'(frame_cnt), 64'd1);
    @(negedge clk);
    check("solid frame1", 64'({rgb_valid, r, g, b}), 64'({1'b1, 8'd1, 8'd1, 8'd1}));

    // enable dropped at clock 20: frame completes, then idles
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0;
    pattern = 2'd1;
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    wait_sig(0, 20, n);
    repeat (20) @(negedge clk);
    enable = 1'b0;
    wait_sig(1, 300, n);
    check("drain frame_done", 64'(n), 64'(FRAME - 1 - 21));
    check("drain frame_cnt", 64'(frame_cnt), 64'd1);
    vs_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rgb_vsync) vs_seen++;
    end
    check("idle no vsync", 64'(vs_seen), 64'd0);
    enable = 1'b1;
    wait_sig(0, 20, n);
    check("re-enable latency", 64'(n), 64'd1);

    // frame_cnt wrap from 0xFFFF
    repeat (10) @(negedge clk);
    chk_en = 1'b0;
    force dut.fcnt_q = 16'hFFFF;
    preset_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    release dut.fcnt_q;
    preset_req = 1'b0;
    chk_en = 1'b1;
    wait_sig(1, 300, n);
    check("wrap frame_done", 64'(n >= 0), 64'd1);
    check("wrap frame_cnt", 64'(frame_cnt), 64'd0);

    // Random enable/pattern activity against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) pattern = 2'($urandom_range(0, 3));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
